tipi_rpi_shift: RTL

RPi-side endpoint of the TIPI mailbox. The TI-facing latch captures TI writes to 0x5fff (data) and 0x5ffd (control). This block exports those two bytes to the Raspberry Pi over a GPIO-driven serial shift protocol. It also accepts the RPi's reply bytes, which the TI reads at 0x5ffb (data) and 0x5ff9 (control). It sits between the TI-side latch outputs and the RPi GPIO header, clocked from the 50 MHz board clock.

---
 rtl/tipi_rpi_shift_if.sv | 28 ++
 rtl/tipi_rpi_shift.sv | 133 +++++++++++++
 2 files changed

// File: rtl/tipi_rpi_shift_if.sv
// RPi GPIO header lines of the TIPI mailbox serial link.
// The RPi drives the master side and this block presents the slave side.
interface tipi_rpi_shift_if;
  logic r_clk;
  logic r_le;
  logic r_cd;
  logic r_rt;
  logic r_dout;
  logic r_din;

  modport master (
    output r_clk,
    output r_le,
    output r_cd,
    output r_rt,
    output r_dout,
    input  r_din
  );

  modport slave (
    input  r_clk,
    input  r_le,
    input  r_cd,
    input  r_rt,
    input  r_dout,
    output r_din
  );
endinterface

// File: rtl/tipi_rpi_shift.sv
// RPi-side endpoint of the TIPI mailbox: serialises the TI bytes out to the RPi
// and deserialises the RPi reply bytes, with framing checks on each commit.
module tipi_rpi_shift #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   ti_reset,
  input  logic [7:0]             tid_q,
  input  logic [7:0]             tic_q,
  tipi_rpi_shift_if.slave        rpi,
  output logic [7:0]             rd_q,
  output logic [7:0]             rc_q,
  output logic                   upd,
  output logic                   frame_err
);

  localparam int unsigned TOP   = SYNC_STAGES - 1;
  localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PART,
    ST_FULL,
    ST_OVER
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] le_sync;
  logic [SYNC_STAGES-1:0] cd_sync;
  logic [SYNC_STAGES-1:0] rt_sync;
  logic [SYNC_STAGES-1:0] dout_sync;
  logic                   clk_hist;
  logic                   le_hist;
  logic [ARM_W-1:0]       arm_cnt;
  logic                   armed;
  logic                   clk_rise;
  logic                   le_rise;

  state_t                 state;
  logic [2:0]             bit_cnt;
  logic [7:0]             sr;
  logic                   r_din_q;

  // Metastability chains on every asynchronous RPi line
  always_ff @(posedge clk or negedge ti_reset) begin
    if (!ti_reset) begin
      clk_sync  <= '0;
      le_sync   <= '0;
      cd_sync   <= '0;
      rt_sync   <= '0;
      dout_sync <= '0;
      clk_hist  <= 1'b0;
      le_hist   <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0],  rpi.r_clk};
      le_sync   <= {le_sync[SYNC_STAGES-2:0],   rpi.r_le};
      cd_sync   <= {cd_sync[SYNC_STAGES-2:0],   rpi.r_cd};
      rt_sync   <= {rt_sync[SYNC_STAGES-2:0],   rpi.r_rt};
      dout_sync <= {dout_sync[SYNC_STAGES-2:0], rpi.r_dout};
      clk_hist  <= clk_sync[TOP];
      le_hist   <= le_sync[TOP];
    end
  end

  // Hold off edge detection until lines high at reset have flushed through
  always_ff @(posedge clk or negedge ti_reset) begin
    if (!ti_reset) begin
      arm_cnt <= '0;
    end else if (arm_cnt != ARM_MAX) begin
      arm_cnt <= arm_cnt + ARM_W'(1);
    end
  end

  assign armed    = (arm_cnt == ARM_MAX);
  assign le_rise  = armed & le_sync[TOP] & ~le_hist;
  assign clk_rise = armed & clk_sync[TOP] & ~clk_hist;

  // Shift register, bit-count FSM and commit logic; a latch edge masks a
  // coincident clock edge
  always_ff @(posedge clk or negedge ti_reset) begin
    if (!ti_reset) begin
      state     <= ST_EMPTY;
      bit_cnt   <= 3'd0;
      sr        <= 8'h00;
      rd_q      <= 8'h00;
      rc_q      <= 8'h00;
      upd       <= 1'b0;
      frame_err <= 1'b0;
      r_din_q   <= 1'b0;
    end else begin
      upd       <= 1'b0;
      frame_err <= 1'b0;
      r_din_q   <= sr[7];
      if (le_rise) begin
        state   <= ST_EMPTY;
        bit_cnt <= 3'd0;
        if (rt_sync[TOP]) begin
          sr <= cd_sync[TOP] ? tic_q : tid_q;
        end else if (state == ST_FULL) begin
          if (cd_sync[TOP]) begin
            rc_q <= sr;
          end else begin
            rd_q <= sr;
          end
          upd <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end else if (clk_rise) begin
        sr <= {sr[6:0], dout_sync[TOP]};
        case (state)
          ST_EMPTY: begin
            state   <= ST_PART;
            bit_cnt <= 3'd1;
          end
          ST_PART: begin
            if (bit_cnt == 3'd7) begin
              state <= ST_FULL;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          ST_FULL:  state <= ST_OVER;
          default:  state <= ST_OVER;
        endcase
      end
    end
  end

  assign rpi.r_din = r_din_q;

endmodule
